// File: rtl/tb_dump_pkg.sv
// ---------------------------------------------------------------------------
// tb_dump_pkg
// Shared definitions for the trace-buffer dump sequencer:
//   - dump_state_t    : sequencer FSM state encoding
//   - bytes_per_entry : number of UART bytes in one trace-buffer entry
// ---------------------------------------------------------------------------
package tb_dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT_RD,
    ST_SEND,
    ST_GUARD,
    ST_WAIT_TX,
    ST_FINISH
  } dump_state_t;

  // An entry is n lanes of data_width bits; data_width is a multiple of 8.
  function automatic int bytes_per_entry(input int n, input int data_width);
    return (n * data_width) / 8;
  endfunction

endpackage

// File: rtl/tb_dump_serializer.sv
// ---------------------------------------------------------------------------
// tb_dump_serializer
// Holds one trace-buffer entry and presents it a byte at a time, LSB byte
// first. The controlling FSM decides when a byte has been accepted by the
// UART and asks for the next one with `shift`.
// Ports:
//   clk, reset   rising-edge clock, asynchronous active-low reset
//   load         capture load_data and restart the byte count
//   load_data    full entry (WORD_WIDTH bits)
//   shift        advance to the next byte of the entry
//   tx_byte      byte currently presented
//   word_empty   tx_byte is the last byte of the entry
// ---------------------------------------------------------------------------
module tb_dump_serializer #(
  parameter int WORD_WIDTH = 256,
  parameter int BPE        = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [WORD_WIDTH-1:0] load_data,
  input  logic                  shift,
  output logic [7:0]            tx_byte,
  output logic                  word_empty
);

  localparam int CW = (BPE > 1) ? $clog2(BPE) : 1;

  logic [WORD_WIDTH-1:0] shift_reg;
  logic [CW-1:0]         byte_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_reg <= '0;
      byte_cnt  <= '0;
    end else if (load) begin
      shift_reg <= load_data;
      byte_cnt  <= '0;
    end else if (shift) begin
      shift_reg <= shift_reg >> 8;
      byte_cnt  <= byte_cnt + 1'b1;
    end
  end

  assign tx_byte    = shift_reg[7:0];
  assign word_empty = (byte_cnt == CW'(BPE - 1));

endmodule

// File: rtl/tb_dump_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dump_ctrl
// Trace-buffer readout sequencer. On `start` it reads every trace-buffer
// entry in address order and streams each entry to the UART byte by byte
// (entry 0 first, lane 0 first, LSB byte first), pacing on tx_busy. Tracing
// is frozen for the whole dump.
//
// Optional feature macro: TB_DUMP_CHECKSUM_EN
//   defined   -> one trailer byte (XOR of every data byte) follows the data
//   undefined -> no trailer; done follows the last data byte
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-low reset
//   start           dump request, only honoured in IDLE
//   tb_mem_address  trace-buffer read address (entry counter)
//   tb_rd_en        one-cycle read strobe
//   tb_rd_data      entry data, valid RD_LATENCY cycles after tb_rd_en
//   tx_data         byte to UART (valid with new_tx_data)
//   new_tx_data     one-cycle send strobe
//   tx_busy         UART transmitter busy
//   freeze          tracing must not write the trace buffer
//   busy            dump in progress
//   done            one-cycle pulse after the final byte is accepted
// ---------------------------------------------------------------------------
module tb_dump_ctrl
  import tb_dump_pkg::*;
#(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TB_SIZE    = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic [$clog2(TB_SIZE)-1:0] tb_mem_address,
  output logic                       tb_rd_en,
  input  logic [N*DATA_WIDTH-1:0]    tb_rd_data,
  output logic [7:0]                 tx_data,
  output logic                       new_tx_data,
  input  logic                       tx_busy,
  output logic                       freeze,
  output logic                       busy,
  output logic                       done
);

  localparam int              WORD_WIDTH = N * DATA_WIDTH;
  localparam int              BPE        = bytes_per_entry(N, DATA_WIDTH);
  localparam int              AW         = $clog2(TB_SIZE);
  localparam logic [1:0]      LAST_WAIT  = 2'(RD_LATENCY - 1);
  localparam logic [AW-1:0]   LAST_ENTRY = AW'(TB_SIZE - 1);

  dump_state_t   state;
  logic [AW-1:0] entry_cnt;
  logic [1:0]    wait_cnt;
  logic          rd_en_reg;
  logic          strobe_reg;
  logic          busy_reg;
  logic          freeze_reg;
  logic          done_reg;

  logic          ser_load;
  logic          ser_shift;
  logic [7:0]    ser_byte;
  logic          word_empty;
  logic [7:0]    send_byte;
  logic          trailer;     // currently sending the checksum trailer

`ifdef TB_DUMP_CHECKSUM_EN
  logic [7:0]    csum_reg;
  assign send_byte = trailer ? csum_reg : ser_byte;
`else
  assign trailer   = 1'b0;
  assign send_byte = ser_byte;
`endif

  // Read data is captured on the last WAIT_RD cycle; the register only
  // shifts when another byte of the same entry is about to be sent.
  assign ser_load  = (state == ST_WAIT_RD) && (wait_cnt == LAST_WAIT);
  assign ser_shift = (state == ST_WAIT_TX) && !tx_busy && !word_empty && !trailer;

  tb_dump_serializer #(
    .WORD_WIDTH (WORD_WIDTH),
    .BPE        (BPE)
  ) u_serializer (
    .clk        (clk),
    .reset      (reset),
    .load       (ser_load),
    .load_data  (tb_rd_data),
    .shift      (ser_shift),
    .tx_byte    (ser_byte),
    .word_empty (word_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      entry_cnt  <= '0;
      wait_cnt   <= '0;
      rd_en_reg  <= 1'b0;
      strobe_reg <= 1'b0;
      busy_reg   <= 1'b0;
      freeze_reg <= 1'b0;
      done_reg   <= 1'b0;
`ifdef TB_DUMP_CHECKSUM_EN
      trailer    <= 1'b0;
      csum_reg   <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_READ;
            rd_en_reg  <= 1'b1;
            busy_reg   <= 1'b1;
            freeze_reg <= 1'b1;
`ifdef TB_DUMP_CHECKSUM_EN
            trailer    <= 1'b0;
            csum_reg   <= '0;
`endif
          end
        end

        ST_READ: begin
          rd_en_reg <= 1'b0;
          wait_cnt  <= '0;
          state     <= ST_WAIT_RD;
        end

        ST_WAIT_RD: begin
          if (wait_cnt == LAST_WAIT) begin
            state      <= ST_SEND;
            // If the UART is still busy the strobe is withheld in SEND.
            strobe_reg <= !tx_busy;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end

        ST_SEND: begin
          if (strobe_reg) begin
            strobe_reg <= 1'b0;
            state      <= ST_GUARD;
`ifdef TB_DUMP_CHECKSUM_EN
            if (!trailer) begin
              csum_reg <= csum_reg ^ ser_byte;
            end
`endif
          end else if (!tx_busy) begin
            strobe_reg <= 1'b1;
          end
        end

        // Gives the UART one cycle to raise tx_busy for the byte just sent.
        ST_GUARD: begin
          state <= ST_WAIT_TX;
        end

        ST_WAIT_TX: begin
          if (!tx_busy) begin
            if (trailer) begin
              state    <= ST_FINISH;
              done_reg <= 1'b1;
            end else if (!word_empty) begin
              state      <= ST_SEND;
              strobe_reg <= 1'b1;
            end else begin
              // Entry finished; the counter wraps to 0 after the last entry.
              entry_cnt <= entry_cnt + 1'b1;
              if (entry_cnt == LAST_ENTRY) begin
`ifdef TB_DUMP_CHECKSUM_EN
                trailer    <= 1'b1;
                state      <= ST_SEND;
                strobe_reg <= 1'b1;
`else
                state    <= ST_FINISH;
                done_reg <= 1'b1;
`endif
              end else begin
                state     <= ST_READ;
                rd_en_reg <= 1'b1;
              end
            end
          end
        end

        ST_FINISH: begin
          state      <= ST_IDLE;
          busy_reg   <= 1'b0;
          freeze_reg <= 1'b0;
          done_reg   <= 1'b0;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign tb_mem_address = entry_cnt;
  assign tb_rd_en       = rd_en_reg;
  assign new_tx_data    = strobe_reg;
  assign tx_data        = (state == ST_SEND) ? send_byte : 8'h00;
  assign busy           = busy_reg;
  assign freeze         = freeze_reg;
  assign done           = done_reg;

endmodule

// File: tb/tb_tb_dump_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tb_dump_ctrl
// Directed bench for tb_dump_ctrl. dut1 uses RD_LATENCY=1 against a UART
// model that stays busy for 10 cycles after each strobe; dut2 uses
// RD_LATENCY=2 against an always-ready UART. Both must produce the same
// byte stream, built here from the lane table.
// ---------------------------------------------------------------------------
module tb_tb_dump_ctrl;

  localparam int N   = 8;
  localparam int DW  = 32;
  localparam int TBS = 8;
  localparam int BPE = N * DW / 8;
  localparam int AW  = 3;
`ifdef TB_DUMP_CHECKSUM_EN
  localparam int TOTAL = TBS * BPE + 1;
`else
  localparam int TOTAL = TBS * BPE;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut1 signals
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] tb_mem_address;
  logic          tb_rd_en;
  logic [N*DW-1:0] tb_rd_data = '0;
  logic [7:0]    tx_data;
  logic          new_tx_data;
  logic          tx_busy = 1'b0;
  logic          freeze, busy, done;

  // dut2 signals
  logic          reset2 = 1'b0;
  logic          start2 = 1'b0;
  logic [AW-1:0] tb_mem_address2;
  logic          tb_rd_en2;
  logic [N*DW-1:0] tb_rd_data2 = '0;
  logic [N*DW-1:0] rd_stage2 = '0;
  logic [7:0]    tx_data2;
  logic          new_tx_data2;
  logic          tx_busy2 = 1'b0;
  logic          freeze2, busy2, done2;

  logic [N*DW-1:0] mem [TBS];
  logic [7:0] exp_q[$];
  logic [7:0] log1[$];
  logic [7:0] log2[$];

  int total = 0;
  int bad = 0;
  int busy_cnt = 0;
  logic hold_busy = 1'b0;
  int busy_viol = 0;
  int done_cnt = 0;
  int done2_cnt = 0;
  int rd_count[TBS];
  int n_hold;

  tb_dump_ctrl #(.N(N), .DATA_WIDTH(DW), .TB_SIZE(TBS), .RD_LATENCY(1)) dut1 (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .tb_mem_address (tb_mem_address),
    .tb_rd_en       (tb_rd_en),
    .tb_rd_data     (tb_rd_data),
    .tx_data        (tx_data),
    .new_tx_data    (new_tx_data),
    .tx_busy        (tx_busy),
    .freeze         (freeze),
    .busy           (busy),
    .done           (done)
  );

  tb_dump_ctrl #(.N(N), .DATA_WIDTH(DW), .TB_SIZE(TBS), .RD_LATENCY(2)) dut2 (
    .clk            (clk),
    .reset          (reset2),
    .start          (start2),
    .tb_mem_address (tb_mem_address2),
    .tb_rd_en       (tb_rd_en2),
    .tb_rd_data     (tb_rd_data2),
    .tx_data        (tx_data2),
    .new_tx_data    (new_tx_data2),
    .tx_busy        (tx_busy2),
    .freeze         (freeze2),
    .busy           (busy2),
    .done           (done2)
  );

  // Trace-buffer models: 1-cycle and 2-cycle read latency.
  always @(posedge clk) begin
    if (tb_rd_en) tb_rd_data <= mem[tb_mem_address];
    if (tb_rd_en2) rd_stage2 <= mem[tb_mem_address2];
    tb_rd_data2 <= rd_stage2;
  end

  // UART model and monitors, evaluated away from the active edge.
  always @(negedge clk) begin
    if (new_tx_data) begin
      if (tx_busy) busy_viol++;
      log1.push_back(tx_data);
      busy_cnt = 10;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    tx_busy = (busy_cnt != 0) || hold_busy;
    if (tb_rd_en) rd_count[tb_mem_address]++;
    if (done) done_cnt++;
    if (new_tx_data2) log2.push_back(tx_data2);
    if (done2) done2_cnt++;
  end

  function automatic logic [31:0] lane_val(input int e, input int l);
    logic [31:0] v;
    if (e == 0 && l == 0)      v = 32'h00057CF6;
    else if (e == 0 && l == 1) v = 32'h000726E3;
    else v = {8'(e * 8 + l + 1), 8'(8'hA5 ^ e), 8'(l * 17), 8'(e * 31 + l * 7 + 3)};
    return v;
  endfunction

  function automatic int diff_count(input logic [7:0] got[$]);
    int d = 0;
    for (int i = 0; i < TOTAL; i++) begin
      if (i >= got.size()) d++;
      else if (got[i] !== exp_q[i]) d++;
    end
    return d;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_bytes(input int n, input int limit);
    int c = 0;
    while (log1.size() < n && c < limit) begin
      @(posedge clk); #1;
      c++;
    end
    check("wait_bytes", 64'(log1.size() >= n), 64'd1);
  endtask

  task automatic wait_done(input int limit);
    int c = 0;
    while (done_cnt < 1 && c < limit) begin
      @(posedge clk); #1;
      c++;
    end
    check("wait_done", 64'(done_cnt >= 1), 64'd1);
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  logic [7:0] first8 [8];

  initial begin
    logic [7:0] csum;
    logic [31:0] v;
    int c;

    first8 = '{8'hF6, 8'h7C, 8'h05, 8'h00, 8'hE3, 8'h26, 8'h07, 8'h00};
    csum = 8'h00;
    for (int e = 0; e < TBS; e++) begin
      for (int l = 0; l < N; l++) begin
        v = lane_val(e, l);
        mem[e][l*DW +: DW] = v;
        for (int b = 0; b < 4; b++) begin
          exp_q.push_back(v[8*b +: 8]);
          csum = csum ^ v[8*b +: 8];
        end
      end
    end
`ifdef TB_DUMP_CHECKSUM_EN
    exp_q.push_back(csum);
`endif
    for (int i = 0; i < TBS; i++) rd_count[i] = 0;

    // Reset held low: everything quiet.
    repeat (3) tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_freeze", 64'(freeze), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rd_en", 64'(tb_rd_en), 64'd0);
    check("rst_addr", 64'(tb_mem_address), 64'd0);
    check("rst_strobe", 64'(new_tx_data), 64'd0);
    check("rst_tx_data", 64'(tx_data), 64'd0);

    reset = 1'b1;
    reset2 = 1'b1;
    repeat (4) tick();
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_rd_en", 64'(tb_rd_en), 64'd0);
    check("idle_strobe", 64'(new_tx_data), 64'd0);

    // start sampled at edge k; READ in the window after edge k.
    start = 1'b1;
    start2 = 1'b1;
    tick();
    start = 1'b0;
    start2 = 1'b0;
    check("read_rd_en", 64'(tb_rd_en), 64'd1);
    check("read_busy", 64'(busy), 64'd1);
    check("read_freeze", 64'(freeze), 64'd1);
    check("read_addr", 64'(tb_mem_address), 64'd0);
    check("read_rd_en2", 64'(tb_rd_en2), 64'd1);
    tick();
    check("waitrd_strobe", 64'(new_tx_data), 64'd0);
    check("waitrd_rd_en", 64'(tb_rd_en), 64'd0);
    check("waitrd_strobe2", 64'(new_tx_data2), 64'd0);
    tick();
    check("first_strobe", 64'(new_tx_data), 64'd1);
    check("first_byte", 64'(tx_data), 64'hF6);
    check("lat2_strobe_early", 64'(new_tx_data2), 64'd0);
    tick();
    check("lat2_first_strobe", 64'(new_tx_data2), 64'd1);
    check("lat2_first_byte", 64'(tx_data2), 64'hF6);

    // Stall at byte 40 with a redundant start pulse.
    wait_bytes(40, 2000);
    hold_busy = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_hold = log1.size();
    repeat (50) tick();
    check("hold_no_bytes", 64'(log1.size()), 64'(n_hold));
    check("hold_still_busy", 64'(busy), 64'd1);
    hold_busy = 1'b0;

    wait_done(8000);
    repeat (3) tick();
    check("end_busy", 64'(busy), 64'd0);
    check("end_freeze", 64'(freeze), 64'd0);
    check("done_count", 64'(done_cnt), 64'd1);
    check("byte_count", 64'(log1.size()), 64'(TOTAL));
    check("byte_stream", 64'(diff_count(log1)), 64'd0);
    for (int i = 0; i < 8; i++) check($sformatf("head_byte%0d", i), 64'(log1[i]), 64'(first8[i]));
    for (int i = 0; i < TBS; i++) check($sformatf("reads_addr%0d", i), 64'(rd_count[i]), 64'd1);
    check("no_strobe_while_busy", 64'(busy_viol), 64'd0);

    c = 0;
    while (done2_cnt < 1 && c < 2000) begin
      tick();
      c++;
    end
    check("lat2_done_count", 64'(done2_cnt), 64'd1);
    check("lat2_byte_count", 64'(log2.size()), 64'(TOTAL));
    check("lat2_byte_stream", 64'(diff_count(log2)), 64'd0);

    // Reset in the middle of a dump.
    log1.delete();
    done_cnt = 0;
    for (int i = 0; i < TBS; i++) rd_count[i] = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_bytes(100, 3000);
    reset = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_freeze", 64'(freeze), 64'd0);
    check("midrst_rd_en", 64'(tb_rd_en), 64'd0);
    check("midrst_strobe", 64'(new_tx_data), 64'd0);
    check("midrst_tx_data", 64'(tx_data), 64'd0);
    check("midrst_addr", 64'(tb_mem_address), 64'd0);
    tick();
    reset = 1'b1;
    repeat (20) tick();
    check("midrst_no_done", 64'(done_cnt), 64'd0);
    check("midrst_idle", 64'(busy), 64'd0);

    // Fresh dump must start over at entry 0.
    log1.delete();
    for (int i = 0; i < TBS; i++) rd_count[i] = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_bytes(1, 100);
    check("restart_first_byte", 64'(log1[0]), 64'hF6);
    wait_done(8000);
    repeat (3) tick();
    check("restart_byte_count", 64'(log1.size()), 64'(TOTAL));
    check("restart_byte_stream", 64'(diff_count(log1)), 64'd0);
    for (int i = 0; i < TBS; i++) check($sformatf("restart_reads%0d", i), 64'(rd_count[i]), 64'd1);
    check("restart_done_count", 64'(done_cnt), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
